// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: holds the fetch PC, issues one AR/R read per
// instruction, hands {pc, inst} to decode over valid/ready and honours
// redirects from execute. One fetch outstanding at most, no prefetch.
module ysyx_25020037_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // decode handoff
    output logic        ifu_valid,
    input  logic        idu_ready,
    output logic [63:0] fu_to_du_bus,
    // redirect from execute
    input  logic        exu_dnpc_valid,
    input  logic [31:0] exu_dnpc,
    // read address channel
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    // read data channel
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // sticky fetch error
    output logic        ifu_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_araddr;
    logic [63:0] r_bus;
    logic        r_flush;
    logic        r_err;

    logic [31:0] w_dnpc_tgt;
    logic [31:0] w_pc_seq;
    logic        w_resp_ok;

    assign w_dnpc_tgt = {exu_dnpc[31:2], 2'b00};
    assign w_pc_seq   = r_pc + 32'(PC_STEP);
    assign w_resp_ok  = (rresp == 2'b00);

    // Handshake outputs are pure state decodes, so no input reaches them
    // combinationally; araddr and the decode bus come from registers.
    assign arvalid      = (r_state == S_REQ);
    assign rready       = (r_state == S_WAIT);
    assign ifu_valid    = (r_state == S_HOLD);
    assign araddr       = r_araddr;
    assign fu_to_du_bus = r_bus;
    assign ifu_err      = r_err;

    // Fetch sequencer: state, PC, in-flight address, flush tracking and handoff data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_araddr <= 32'h0000_0000;
            r_bus    <= 64'h0;
            r_flush  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Idle after reset guarantees no stale R beat is accepted.
                    r_araddr <= r_pc;
                    r_state  <= S_REQ;
                end
                S_REQ: begin
                    // The address already presented stays put until accepted;
                    // a redirect only retargets the PC and marks the reply stale.
                    if (exu_dnpc_valid) begin
                        r_pc    <= w_dnpc_tgt;
                        r_flush <= 1'b1;
                    end
                    if (arready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rvalid) begin
                        if (r_flush || exu_dnpc_valid) begin
                            // Stale beat: drop it and refetch from the current target.
                            r_flush <= 1'b0;
                            r_state <= S_REQ;
                            if (exu_dnpc_valid) begin
                                r_pc     <= w_dnpc_tgt;
                                r_araddr <= w_dnpc_tgt;
                            end else begin
                                r_araddr <= r_pc;
                            end
                        end else begin
                            // Faulting fetch hands decode a zero word and latches the error.
                            r_bus   <= {r_pc, (w_resp_ok ? rdata : 32'h0000_0000)};
                            r_err   <= r_err | ~w_resp_ok;
                            r_state <= S_HOLD;
                        end
                    end else if (exu_dnpc_valid) begin
                        // Latest redirect wins until the reply shows up.
                        r_pc    <= w_dnpc_tgt;
                        r_flush <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect beats the handoff: the held instruction is squashed.
                    if (exu_dnpc_valid) begin
                        r_pc     <= w_dnpc_tgt;
                        r_araddr <= w_dnpc_tgt;
                        r_state  <= S_REQ;
                    end else if (idu_ready) begin
                        r_pc     <= w_pc_seq;
                        r_araddr <= w_pc_seq;
                        r_state  <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed bench for the fetch unit: the bench plays the memory side and
// decode/execute by hand, with expected values worked out per step.
module tb_ysyx_25020037_ifu;

    logic        clk;
    logic        rst_n;
    logic        ifu_valid;
    logic        idu_ready;
    logic [63:0] fu_to_du_bus;
    logic        exu_dnpc_valid;
    logic [31:0] exu_dnpc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        ifu_err;

    int checks_cnt;
    int fail_cnt;

    ysyx_25020037_ifu u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_valid      (ifu_valid),
        .idu_ready      (idu_ready),
        .fu_to_du_bus   (fu_to_du_bus),
        .exu_dnpc_valid (exu_dnpc_valid),
        .exu_dnpc       (exu_dnpc),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .ifu_err        (ifu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt = checks_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".arvalid"},   64'(arvalid),   64'h0);
        chk({tag, ".rready"},    64'(rready),    64'h0);
        chk({tag, ".ifu_valid"}, 64'(ifu_valid), 64'h0);
        chk({tag, ".bus"},       fu_to_du_bus,   64'h0);
        chk({tag, ".ifu_err"},   64'(ifu_err),   64'h0);
    endtask

    logic [63:0] held_bus;

    initial begin
        checks_cnt     = 0;
        fail_cnt       = 0;
        rst_n          = 1'b0;
        idu_ready      = 1'b0;
        exu_dnpc_valid = 1'b0;
        exu_dnpc       = 32'h0;
        arready        = 1'b0;
        rdata          = 32'h0;
        rresp          = 2'b00;
        rvalid         = 1'b0;

        // ---- reset state ----
        #3;
        chk_zero_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // ---- first fetch ----
        tick();                                   // IDLE -> REQ
        chk("f1.arvalid", 64'(arvalid), 64'h1);
        chk("f1.araddr",  64'(araddr),  64'h3000_0000);
        chk("f1.ifu_valid", 64'(ifu_valid), 64'h0);
        arready = 1'b1;
        tick();                                   // REQ -> WAIT
        arready = 1'b0;
        chk("f1.rready",  64'(rready),  64'h1);
        chk("f1.arvalid_wait", 64'(arvalid), 64'h0);
        rvalid = 1'b1; rdata = 32'h0010_0093;
        tick();                                   // WAIT -> HOLD
        rvalid = 1'b0; rdata = 32'h0;
        chk("f1.ifu_valid_hold", 64'(ifu_valid), 64'h1);
        chk("f1.bus", fu_to_du_bus, 64'h3000_0000_0010_0093);

        // ---- decode stall ----
        held_bus = 64'h3000_0000_0010_0093;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.bus",       fu_to_du_bus,     held_bus);
            chk("stall.arvalid",   64'(arvalid),     64'h0);
            chk("stall.ifu_valid", 64'(ifu_valid),   64'h1);
        end
        idu_ready = 1'b1;
        tick();                                   // HOLD -> REQ, single handoff
        idu_ready = 1'b0;
        chk("adv.ifu_valid", 64'(ifu_valid), 64'h0);
        chk("adv.araddr",    64'(araddr),    64'h3000_0004);
        chk("adv.arvalid",   64'(arvalid),   64'h1);

        // ---- second fetch ----
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0020_8113;
        tick();
        rvalid = 1'b0;
        chk("f2.bus", fu_to_du_bus, 64'h3000_0004_0020_8113);

        // ---- redirect in HOLD beats idu_ready ----
        exu_dnpc_valid = 1'b1; exu_dnpc = 32'h3000_0103; idu_ready = 1'b1;
        tick();
        exu_dnpc_valid = 1'b0; idu_ready = 1'b0;
        chk("rdh.ifu_valid", 64'(ifu_valid), 64'h0);
        chk("rdh.araddr",    64'(araddr),    64'h3000_0100);
        chk("rdh.arvalid",   64'(arvalid),   64'h1);

        // ---- redirect during outstanding fetch ----
        arready = 1'b1;
        tick();                                   // -> WAIT
        arready = 1'b0;
        exu_dnpc_valid = 1'b1; exu_dnpc = 32'h3000_0200;
        tick();                                   // still WAIT, flush set
        exu_dnpc_valid = 1'b0;
        chk("rdw.rready",    64'(rready),    64'h1);
        chk("rdw.ifu_valid", 64'(ifu_valid), 64'h0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();                                   // beat discarded -> REQ
        rvalid = 1'b0;
        chk("rdw.ifu_valid_after", 64'(ifu_valid), 64'h0);
        chk("rdw.arvalid", 64'(arvalid), 64'h1);
        chk("rdw.araddr",  64'(araddr),  64'h3000_0200);
        chk("rdw.ifu_err", 64'(ifu_err), 64'h0);

        // ---- AR back-pressure ----
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp.araddr",  64'(araddr),  64'h3000_0200);
            chk("bp.arvalid", 64'(arvalid), 64'h1);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;

        // ---- error response ----
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("err.ifu_valid", 64'(ifu_valid), 64'h1);
        chk("err.bus",       fu_to_du_bus,   64'h3000_0200_0000_0000);
        chk("err.ifu_err",   64'(ifu_err),   64'h1);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        chk("err.araddr_next", 64'(araddr),  64'h3000_0204);
        chk("err.sticky",      64'(ifu_err), 64'h1);

        // ---- redirect coinciding with arready ----
        exu_dnpc_valid = 1'b1; exu_dnpc = 32'h3000_0300; arready = 1'b1;
        tick();                                   // handshake completes, flush set
        exu_dnpc_valid = 1'b0; arready = 1'b0;
        chk("rda.rready", 64'(rready), 64'h1);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        tick();
        rvalid = 1'b0;
        chk("rda.ifu_valid", 64'(ifu_valid), 64'h0);
        chk("rda.araddr",    64'(araddr),    64'h3000_0300);

        // ---- redirect in REQ under back-pressure, then PC wrap ----
        exu_dnpc_valid = 1'b1; exu_dnpc = 32'hFFFF_FFFE;
        tick();
        exu_dnpc_valid = 1'b0;
        chk("rdr.araddr_stable", 64'(araddr), 64'h3000_0300);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1111_1111;
        tick();                                   // stale beat dropped
        rvalid = 1'b0;
        chk("rdr.araddr", 64'(araddr), 64'hFFFF_FFFC);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0013;
        tick();
        rvalid = 1'b0;
        chk("wrap.bus", fu_to_du_bus, 64'hFFFF_FFFC_0000_0013);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        chk("wrap.araddr", 64'(araddr), 64'h0);

        // ---- asynchronous reset while in WAIT ----
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("ar.rready_wait", 64'(rready), 64'h1);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;     // stale beat held across reset
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("arst");
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst.rready_rel", 64'(rready), 64'h0);
        tick();                                   // IDLE -> REQ
        rvalid = 1'b0;
        chk("arst.arvalid", 64'(arvalid),   64'h1);
        chk("arst.araddr",  64'(araddr),    64'h3000_0000);
        chk("arst.ifu_valid", 64'(ifu_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
